xilinx_sp_bram_obi: RTL and testbench



---
 rtl/xilinx_sp_bram_obi.sv | 155 +++++++++++++++
 tb/tb_xilinx_sp_bram_obi.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xilinx_sp_bram_obi.sv
// Single-port block RAM behind an OBI request/grant/response port, with byte enables,
// 1- or 2-cycle read latency and an optional post-reset zero-clear sequencer.
// Build option: define RTSS_BRAM_WRITE_FIRST_EN to make write responses carry the merged row.
module xilinx_sp_bram_obi #(
    parameter int  RAM_WIDTH      = 32,
    parameter int  RAM_DEPTH      = 1024,
    parameter int  READ_LATENCY   = 1,
    parameter int  CLEAR_ON_RESET = 0,
    parameter      INIT_FILE      = "",
    localparam int ADDR_W         = $clog2(RAM_DEPTH),
    localparam int BE_W           = RAM_WIDTH / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [BE_W-1:0]      be_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [RAM_WIDTH-1:0] wdata_i,
    output logic                 rvalid_o,
    output logic [RAM_WIDTH-1:0] rdata_o,
    output logic                 init_done_o
);

    localparam bit                CLEAR_EN = (CLEAR_ON_RESET != 0) && (INIT_FILE == "");
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(RAM_DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic                 rvalid1_q, rvalid1_d;
    logic                 clr_we;
    logic                 accept;
    logic                 addr_ok;
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] arr_dout_q;

    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $fatal(1, "xilinx_sp_bram_obi: READ_LATENCY must be 1 or 2");
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        gnt_o     = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: gnt_o = req_i;
            default: ;
        endcase
    end

    assign accept      = req_i & gnt_o;
    assign addr_ok     = {1'b0, addr_i} < DEPTH_X;
    assign init_done_o = (state_q == ST_READY);
    assign rvalid1_d   = accept;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= CLEAR_EN ? ST_CLEAR : ST_READY;
            clr_cnt_q <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // NOTE: the array and its read latch carry no reset, otherwise they cannot map onto BRAM.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else if (accept && addr_ok && we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (!addr_ok) begin
                arr_dout_q <= '0;
            end else if (!we_i) begin
                arr_dout_q <= mem[addr_i];
            end else begin
`ifdef RTSS_BRAM_WRITE_FIRST_EN
                for (int b = 0; b < BE_W; b++) begin
                    arr_dout_q[8*b +: 8] <= be_i[b] ? wdata_i[8*b +: 8] : mem[addr_i][8*b +: 8];
                end
`else
                arr_dout_q <= '0;
`endif
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                 rvalid2_q, rvalid2_d;
        logic [RAM_WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rvalid2_d = rvalid1_q;
            rdata_d   = rvalid1_q ? arr_dout_q : rdata_q;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid2_q <= 1'b0;
                rdata_q   <= '0;
            end else begin
                rvalid2_q <= rvalid2_d;
                rdata_q   <= rdata_d;
            end
        end

        assign rvalid_o = rvalid2_q;
        assign rdata_o  = rdata_q;
    end else begin : g_lat1
        // The array latch is the output register here; it shows zero until the first response after reset.
        logic seen_q, seen_d;

        always_comb seen_d = seen_q | accept;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                seen_q <= 1'b0;
            end else begin
                seen_q <= seen_d;
            end
        end

        assign rvalid_o = rvalid1_q;
        assign rdata_o  = seen_q ? arr_dout_q : '0;
    end

endmodule

// File: tb/tb_xilinx_sp_bram_obi.sv
// Bench for xilinx_sp_bram_obi: instance A (depth 12, latency 2, clear on reset) and
// instance B (depth 16, latency 1, no clear), checked against an array/queue reference model.
module tb_xilinx_sp_bram_obi;

`ifdef RTSS_BRAM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        req       [2];
    logic        gnt       [2];
    logic        we        [2];
    logic [3:0]  be        [2];
    logic [3:0]  addr      [2];
    logic [31:0] wdata     [2];
    logic        rvalid    [2];
    logic [31:0] rdata     [2];
    logic        init_done [2];

    logic [31:0] model      [2][16];
    logic [31:0] last_rdata [2];
    resp_t       expq       [2][$];
    int          pulses     [2];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    xilinx_sp_bram_obi #(
        .RAM_WIDTH(32), .RAM_DEPTH(12), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]),
        .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .init_done_o(init_done[0])
    );

    xilinx_sp_bram_obi #(
        .RAM_WIDTH(32), .RAM_DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]),
        .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .init_done_o(init_done[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int depth_of(int d);
        return (d == 0) ? 12 : 16;
    endfunction

    function automatic int lat_of(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: order, exact latency, data, and idle hold of rdata.
    always @(negedge clk) begin
        resp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rvalid[d] === 1'b1) begin
                pulses[d]++;
                if (expq[d].size() == 0) begin
                    check($sformatf("spurious_rvalid[%0d]", d), 32'(rvalid[d]), 32'd0);
                end else begin
                    e = expq[d].pop_front();
                    check($sformatf("resp_cycle[%0d]", d), 32'(cyc), 32'(e.due));
                    check($sformatf("resp_data[%0d]", d), rdata[d], e.data);
                    last_rdata[d] = e.data;
                end
            end else begin
                if (expq[d].size() > 0 && expq[d][0].due <= cyc) begin
                    check($sformatf("missing_rvalid[%0d]", d), 32'(rvalid[d]), 32'd1);
                    void'(expq[d].pop_front());
                end
                check($sformatf("rdata_hold[%0d]", d), rdata[d], last_rdata[d]);
            end
        end
    end

    // Issue one transaction (called shortly after a falling edge); leaves req high.
    task automatic xact(int d, bit w, logic [3:0] a, logic [3:0] b, logic [31:0] wd);
        resp_t       e;
        logic [31:0] mask;
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        #1;
        check($sformatf("gnt[%0d]", d), 32'(gnt[d]), 32'd1);
        mask = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) mask = mask | (32'hFF << (8 * i));
        end
        if (int'(a) >= depth_of(d)) begin
            e.data = 32'd0;
        end else if (!w) begin
            e.data = model[d][a];
        end else begin
            model[d][a] = (model[d][a] & ~mask) | (wd & mask);
            e.data = WF ? model[d][a] : 32'd0;
        end
        e.due = cyc + lat_of(d);
        expq[d].push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic idle(int d, int n);
        req[d] = 1'b0; we[d] = 1'b0;
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic read_rows(int d, int n);
        for (int a = 0; a < n; a++) xact(d, 1'b0, 4'(a), 4'hF, 32'd0);
        idle(d, 1);
    endtask

    task automatic reset_pulse(int d);
        req[d] = 1'b0; we[d] = 1'b0;
        rst_n[d] = 1'b0;
        expq[d].delete();
        last_rdata[d] = 32'd0;
        #1;
        check($sformatf("rst_rdata[%0d]", d), rdata[d], 32'd0);
        check($sformatf("rst_rvalid[%0d]", d), 32'(rvalid[d]), 32'd0);
        @(negedge clk); #1;
        check($sformatf("rst_rdata2[%0d]", d), rdata[d], 32'd0);
    endtask

    // Release A from reset and verify the 12-cycle clear window with req held high.
    task automatic clear_check();
        rst_n[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'd0; be[0] = 4'hF;
        #1;
        check("clear_gnt_first", 32'(gnt[0]), 32'd0);
        check("clear_done_first", 32'(init_done[0]), 32'd0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); #1;
            check($sformatf("clear_gnt_c%0d", i + 1), 32'(gnt[0]), 32'd0);
            check($sformatf("clear_done_c%0d", i + 1), 32'(init_done[0]), 32'd0);
        end
        @(negedge clk); #1;
        check("clear_done_end", 32'(init_done[0]), 32'd1);
        check("clear_gnt_end", 32'(gnt[0]), 32'd1);
        req[0] = 1'b0;
        for (int a = 0; a < 12; a++) model[0][a] = 32'd0;
    endtask

    task automatic rand_run(int d, int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] a = 4'($urandom_range(0, 15));
            xact(d, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
        end
        idle(d, 1);
    endtask

    task automatic drain();
        for (int d = 0; d < 2; d++) begin
            int n = 0;
            req[d] = 1'b0;
            while (expq[d].size() > 0 && n < 8) begin
                @(negedge clk); #1;
                n++;
            end
            check($sformatf("drain[%0d]", d), 32'(expq[d].size()), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0;
            addr[d] = 4'd0; wdata[d] = 32'd0; last_rdata[d] = 32'd0; pulses[d] = 0;
        end
        #1;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_done_a", 32'(init_done[0]), 32'd0);
        check("reset_rdata_a", rdata[0], 32'd0);
        check("reset_rvalid_b", 32'(rvalid[1]), 32'd0);

        rst_n[1] = 1'b1;
        #1;
        check("reset_done_b", 32'(init_done[1]), 32'd1);

        // Clear sequence, then every row of A reads zero.
        clear_check();
        read_rows(0, 12);

        // Back-to-back write then read of the same row, exactly two responses.
        p0 = pulses[0];
        xact(0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
        xact(0, 1'b0, 4'd3, 4'hF, 32'd0);
        idle(0, 4);
        check("b2b_pulses", 32'(pulses[0] - p0), 32'd2);

        // Byte enables on row 5, plus a be=0 write that must leave row 2 alone.
        xact(0, 1'b1, 4'd5, 4'hF, 32'h11223344);
        xact(0, 1'b1, 4'd5, 4'b0101, 32'hAABBCCDD);
        xact(0, 1'b0, 4'd5, 4'hF, 32'd0);
        xact(0, 1'b1, 4'd2, 4'h0, 32'hFFFFFFFF);
        xact(0, 1'b0, 4'd2, 4'hF, 32'd0);
        idle(0, 3);

        // Write response data on the latency-1 instance.
        xact(1, 1'b1, 4'd7, 4'hF, 32'h12345678);
        xact(1, 1'b0, 4'd7, 4'hF, 32'd0);
        idle(1, 2);

        // Out-of-range write and read on the depth-12 instance, rows intact afterwards.
        xact(0, 1'b1, 4'd13, 4'hF, 32'hCAFEF00D);
        xact(0, 1'b0, 4'd13, 4'hF, 32'd0);
        xact(0, 1'b0, 4'd15, 4'hF, 32'd0);
        idle(0, 1);
        read_rows(0, 12);

        // Fill B so every row is known, then randomized traffic on both instances.
        for (int a = 0; a < 16; a++) xact(1, 1'b1, 4'(a), 4'hF, $urandom);
        idle(1, 1);
        rand_run(1, 300);
        rand_run(0, 300);
        drain();

        // Make A's rows non-zero, then reset one cycle after a read grant.
        for (int a = 0; a < 12; a++) xact(0, 1'b1, 4'(a), 4'hF, 32'h0101_0101 * (a + 1));
        idle(0, 3);
        p0 = pulses[0];
        xact(0, 1'b0, 4'd3, 4'hF, 32'd0);
        reset_pulse(0);
        clear_check();
        idle(0, 3);
        check("inflight_dropped", 32'(pulses[0] - p0), 32'd0);
        read_rows(0, 12);

        // Reset in the middle of a clear restarts it from row 0.
        for (int a = 0; a < 12; a++) xact(0, 1'b1, 4'(a), 4'hF, $urandom | 32'h1);
        idle(0, 3);
        reset_pulse(0);
        rst_n[0] = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
        end
        reset_pulse(0);
        clear_check();
        read_rows(0, 12);

        // Reset on B keeps memory contents.
        xact(1, 1'b0, 4'd7, 4'hF, 32'd0);
        reset_pulse(1);
        rst_n[1] = 1'b1;
        #1;
        check("reset_done_b2", 32'(init_done[1]), 32'd1);
        read_rows(1, 16);

        drain();
        idle(0, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
